// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared widths and payload type for the pipeline stage register
package pipe_pkg;

    localparam int XLEN_DEF  = 32;
    localparam int SIG_W_DEF = 3;
    localparam int CNT_W_DEF = 16;

    // Field order matches the flattened payload vector used by the stage (signal in the MSBs)
    typedef struct packed {
        logic [SIG_W_DEF-1:0] signal;
        logic [XLEN_DEF-1:0]  npc;
        logic [XLEN_DEF-1:0]  dm_data;
        logic [XLEN_DEF-1:0]  alu_out;
        logic [XLEN_DEF-1:0]  ir;
    } payload_t;

    localparam int PAYLOAD_W_DEF = $bits(payload_t);

endpackage

// File: rtl/pipe_entry.sv
// rtl/pipe_entry.sv - one valid bit plus payload register with load and clear
module pipe_entry
    import pipe_pkg::*;
#(
    parameter int W = PAYLOAD_W_DEF
) (
    input  logic         clk,
    input  logic         clear,
    input  logic         load,
    input  logic         d_valid,
    input  logic [W-1:0] d,
    output logic         q_valid,
    output logic [W-1:0] q
);

    // Clear wins over load; an invalid load stores zeros so an empty entry always reads as a bubble
    always_ff @(posedge clk) begin
        if (clear) begin
            q_valid <= 1'b0;
            q       <= '0;
        end else if (load) begin
            q_valid <= d_valid;
            q       <= d_valid ? d : '0;
        end
    end

endmodule

// File: rtl/pipe_stage_reg.sv
// rtl/pipe_stage_reg.sv - two-entry skid-buffered pipeline stage with stall counter
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int XLEN  = XLEN_DEF,
    parameter int SIG_W = SIG_W_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [SIG_W-1:0] in_signal,
    input  logic [XLEN-1:0]  in_npc,
    input  logic [XLEN-1:0]  in_dm_data,
    input  logic [XLEN-1:0]  in_alu_out,
    input  logic [XLEN-1:0]  in_ir,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [SIG_W-1:0] out_signal,
    output logic [XLEN-1:0]  out_npc,
    output logic [XLEN-1:0]  out_dm_data,
    output logic [XLEN-1:0]  out_alu_out,
    output logic [XLEN-1:0]  out_ir,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam int PW = SIG_W + 4 * XLEN;

    logic [PW-1:0] in_pay;
    logic [PW-1:0] main_q;
    logic [PW-1:0] skid_q;
    logic [PW-1:0] main_d;
    logic          main_valid;
    logic          skid_valid;
    logic          clear;
    logic          accept;
    logic          drain;
    logic          main_free;
    logic          in_to_main;
    logic          main_load;
    logic          main_d_valid;
    logic          skid_load;
    logic          skid_d_valid;

    assign in_pay = {in_signal, in_npc, in_dm_data, in_alu_out, in_ir};
    assign clear  = rst | flush;

    // in_ready is the inverted skid valid flop, so out_ready never reaches it combinationally
    assign in_ready  = ~skid_valid;
    assign accept    = in_valid & in_ready;
    assign drain     = main_valid & out_ready;
    assign main_free = ~main_valid | drain;

    // Input bypasses skid only when main frees up and nothing older is waiting in skid
    always_comb begin
        in_to_main   = main_free & ~skid_valid;
        main_load    = main_free;
        main_d_valid = skid_valid | accept;
        main_d       = skid_valid ? skid_q : in_pay;
        skid_load    = (accept & ~in_to_main) | (skid_valid & drain);
        skid_d_valid = accept & ~in_to_main;
    end

    pipe_entry #(.W(PW)) u_main (
        .clk     (clk),
        .clear   (clear),
        .load    (main_load),
        .d_valid (main_d_valid),
        .d       (main_d),
        .q_valid (main_valid),
        .q       (main_q)
    );

    pipe_entry #(.W(PW)) u_skid (
        .clk     (clk),
        .clear   (clear),
        .load    (skid_load),
        .d_valid (skid_d_valid),
        .d       (in_pay),
        .q_valid (skid_valid),
        .q       (skid_q)
    );

    assign out_valid = main_valid;
    assign {out_signal, out_npc, out_dm_data, out_alu_out, out_ir} = main_q;

    // Saturating count of back-pressured cycles; only reset clears it, flush does not
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (main_valid && !out_ready && (stall_cnt != {CNT_W{1'b1}})) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb/tb_pipe_stage_reg.sv - randomized self-checking bench with queue reference model
module tb_pipe_stage_reg;
    import pipe_pkg::*;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, out_ready;
    logic [2:0]  in_signal;
    logic [31:0] in_npc, in_dm_data, in_alu_out, in_ir;

    logic        in_ready, out_valid;
    logic [2:0]  out_signal;
    logic [31:0] out_npc, out_dm_data, out_alu_out, out_ir;
    logic [15:0] stall_cnt;

    logic        in_ready2, out_valid2;
    logic [2:0]  out_signal2;
    logic [31:0] out_npc2, out_dm_data2, out_alu_out2, out_ir2;
    logic [1:0]  stall_cnt2;

    int checks = 0;
    int errors = 0;

    payload_t mq[$];
    int       mcnt;
    int       mcnt2;

    always #5 clk = ~clk;

    pipe_stage_reg dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_signal(in_signal), .in_npc(in_npc), .in_dm_data(in_dm_data),
        .in_alu_out(in_alu_out), .in_ir(in_ir),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_signal(out_signal), .out_npc(out_npc), .out_dm_data(out_dm_data),
        .out_alu_out(out_alu_out), .out_ir(out_ir),
        .stall_cnt(stall_cnt)
    );

    pipe_stage_reg #(.CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready2),
        .in_signal(in_signal), .in_npc(in_npc), .in_dm_data(in_dm_data),
        .in_alu_out(in_alu_out), .in_ir(in_ir),
        .out_valid(out_valid2), .out_ready(out_ready),
        .out_signal(out_signal2), .out_npc(out_npc2), .out_dm_data(out_dm_data2),
        .out_alu_out(out_alu_out2), .out_ir(out_ir2),
        .stall_cnt(stall_cnt2)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: the stage is a FIFO of depth two; front of queue is what out_* shows
    task automatic model_step();
        payload_t p;
        int       sz;
        p  = '{signal: in_signal, npc: in_npc, dm_data: in_dm_data,
               alu_out: in_alu_out, ir: in_ir};
        sz = mq.size();
        if (rst) begin
            mq.delete();
            mcnt  = 0;
            mcnt2 = 0;
        end else begin
            if (sz > 0 && !out_ready) begin
                if (mcnt < 65535) mcnt++;
                if (mcnt2 < 3) mcnt2++;
            end
            if (flush) begin
                mq.delete();
            end else begin
                if (sz > 0 && out_ready) void'(mq.pop_front());
                if (in_valid && sz < 2) mq.push_back(p);
            end
        end
    endtask

    task automatic compare_all();
        payload_t e;
        e = (mq.size() > 0) ? mq[0] : '0;
        chk("out_valid",   out_valid,   mq.size() > 0);
        chk("in_ready",    in_ready,    mq.size() < 2);
        chk("out_signal",  out_signal,  e.signal);
        chk("out_npc",     out_npc,     e.npc);
        chk("out_dm_data", out_dm_data, e.dm_data);
        chk("out_alu_out", out_alu_out, e.alu_out);
        chk("out_ir",      out_ir,      e.ir);
        chk("stall_cnt",   stall_cnt,   mcnt);
        chk("stall_cnt2",  stall_cnt2,  mcnt2);
        chk("out_ir2",     out_ir2,     e.ir);
        chk("in_ready2",   in_ready2,   mq.size() < 2);
        chk("out_valid2",  out_valid2,  mq.size() > 0);
        chk("out_misc2",   {out_signal2, out_npc2[15:0], out_dm_data2[15:0], out_alu_out2[15:0]},
                           {e.signal, e.npc[15:0], e.dm_data[15:0], e.alu_out[15:0]});
    endtask

    task automatic cyc(input logic r, input logic f, input logic iv, input logic ordy,
                       input logic [31:0] ir);
        rst        = r;
        flush      = f;
        in_valid   = iv;
        out_ready  = ordy;
        in_ir      = ir;
        in_signal  = 3'($urandom);
        in_npc     = $urandom;
        in_dm_data = $urandom;
        in_alu_out = $urandom;
        @(posedge clk);
        model_step();
        #1;
        compare_all();
    endtask

    initial begin
        mcnt  = 0;
        mcnt2 = 0;

        // Reset held two cycles while input is offered
        cyc(1, 0, 1, 0, 32'h11);
        cyc(1, 0, 1, 0, 32'h22);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_ir",    out_ir,    0);
        chk("rst_in_ready",  in_ready,  1);
        chk("rst_stall",     stall_cnt, 0);

        // Streaming with out_ready high
        cyc(0, 0, 1, 1, 32'd1);
        chk("stream_1", out_ir, 32'd1);
        cyc(0, 0, 1, 1, 32'd2);
        chk("stream_2", out_ir, 32'd2);
        chk("stream_rdy", in_ready, 1);
        cyc(0, 0, 1, 1, 32'd3);
        chk("stream_3", out_ir, 32'd3);
        cyc(0, 0, 0, 1, 32'd0);
        chk("stream_empty", out_valid, 0);

        // Back-pressure: A then B, then a third offer that must be refused
        cyc(1, 0, 0, 0, 0);
        cyc(0, 0, 1, 0, 32'hA);
        cyc(0, 0, 1, 0, 32'hB);
        chk("bp_ready", in_ready, 0);
        chk("bp_hold_a", out_ir, 32'hA);
        cyc(0, 0, 1, 0, 32'hD);
        chk("bp_still_a", out_ir, 32'hA);
        cyc(0, 0, 0, 1, 0);
        chk("bp_then_b", out_ir, 32'hB);
        cyc(0, 0, 0, 1, 0);
        chk("bp_drained", out_valid, 0);

        // Stall counter: 5 cycles, then 6 total for the 2-bit instance saturating at 3
        cyc(1, 0, 0, 0, 0);
        cyc(0, 0, 1, 1, 32'h5);
        for (int i = 0; i < 5; i++) cyc(0, 0, 0, 0, 0);
        chk("stall_5", stall_cnt, 5);
        cyc(0, 0, 0, 0, 0);
        chk("stall_sat2", stall_cnt2, 3);
        chk("stall_6", stall_cnt, 6);

        // Flush a full stage while C is offered
        cyc(0, 0, 1, 0, 32'h6);
        chk("fl_full", in_ready, 0);
        cyc(0, 1, 1, 0, 32'hC);
        chk("fl_valid", out_valid, 0);
        chk("fl_ir", out_ir, 0);
        chk("fl_ready", in_ready, 1);
        cyc(0, 0, 0, 1, 0);
        chk("fl_no_c", out_valid, 0);

        // Drain while full with input offered: order kept, refused input never shows
        cyc(0, 0, 1, 0, 32'h71);
        cyc(0, 0, 1, 0, 32'h72);
        cyc(0, 0, 1, 1, 32'h73);
        chk("full_drain_ir", out_ir, 32'h72);
        cyc(0, 0, 0, 1, 0);
        chk("full_drain_empty", out_valid, 0);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            cyc(($urandom_range(0, 199) == 0), ($urandom_range(0, 49) == 0),
                $urandom_range(0, 1), ($urandom_range(0, 2) != 0), $urandom);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
